// File: rtl/hall_pkg.sv
// ============================================================================
//  Module  : hall_pkg
//  Brief   : Shared state encoding and default constants for the hall counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package hall_pkg;

    localparam int c_DEF_CHANNELS       = 2;
    localparam int c_DEF_CNT_W          = 11;
    localparam int c_DEF_SYNC_STAGES    = 2;
    localparam int c_DEF_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } hall_state_t;

endpackage

`default_nettype wire

// File: rtl/hall_channel.sv
// ============================================================================
//  Module  : hall_channel
//  Brief   : One hall channel: synchroniser, edge detect, move FSM and counter.
//            Stall timer present only when HALL_STALL_TIMEOUT_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hall_channel
    import hall_pkg::*;
#(
    parameter int CNT_W          = c_DEF_CNT_W,
    parameter int SYNC_STAGES    = c_DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             hall_in,
    input  logic             load,
    input  logic [CNT_W-1:0] target,
    output logic             run,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] count
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("hall_channel: SYNC_STAGES must be 2..3");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("hall_channel: TIMEOUT_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hall_prev;
    logic                   w_edge;

    hall_state_t            r_state;
    hall_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_target;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [CNT_W-1:0]       w_target_nxt;
    logic [CNT_W-1:0]       w_count_inc;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_sync      <= '0;
            r_hall_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], hall_in};
            r_hall_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_hall_prev;
    assign w_count_inc = r_count + 1'b1;

`ifdef HALL_STALL_TIMEOUT_EN
    localparam int                c_TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMR_W-1:0] r_timer;
    logic               w_stall;

    // Timer measures the gap since the last counted edge (or the load).
    always_ff @(posedge clk) begin
        if (RESET || load) begin
            r_timer <= '0;
        end else if (r_state == RUN) begin
            r_timer <= w_edge ? '0 : r_timer + 1'b1;
        end
    end

    assign w_stall = (r_timer == c_TMR_LAST);
    assign fault   = (r_state == FAULT);
`else
    assign fault   = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        if (load) begin
            w_target_nxt = target;
            w_count_nxt  = '0;
            w_state_nxt  = (target == '0) ? DONE : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_edge) begin
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == r_target) begin
                            w_state_nxt = DONE;
                        end
`ifdef HALL_STALL_TIMEOUT_EN
                    end else if (w_stall) begin
                        w_state_nxt = FAULT;
`endif
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
        end
    end

    assign run   = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hall_pulse_counter.sv
// ============================================================================
//  Module  : hall_pulse_counter
//  Brief   : Multi-channel hall pulse move counter. Define HALL_STALL_TIMEOUT_EN
//            to enable per-channel stall detection (fault output).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hall_pulse_counter
    import hall_pkg::*;
#(
    parameter int CHANNELS       = c_DEF_CHANNELS,
    parameter int CNT_W          = c_DEF_CNT_W,
    parameter int SYNC_STAGES    = c_DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [CHANNELS-1:0]       hall_in,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*CNT_W-1:0] target,
    output logic [CHANNELS-1:0]       run,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       fault
);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("hall_pulse_counter: CHANNELS must be 1..8");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        hall_channel #(
            .CNT_W          (CNT_W),
            .SYNC_STAGES    (SYNC_STAGES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_channel (
            .clk     (clk),
            .RESET   (RESET),
            .hall_in (hall_in[g]),
            .load    (load[g]),
            .target  (target[g*CNT_W +: CNT_W]),
            .run     (run[g]),
            .done    (done[g]),
            .fault   (fault[g]),
            .count   (count[g*CNT_W +: CNT_W])
        );
    end

endmodule

`default_nettype wire
